// File: rtl/mul_add_seq_pkg.sv
// Shared definitions for the sequential multiply-add unit: FSM encoding and default widths.
package mul_add_seq_pkg;
  localparam int DEF_N = 32;
  localparam int DEF_M = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;
endpackage

// File: rtl/mul_add_seq.sv
// Sequential p = x*y + z using one radix-2 shift-add step per cycle for M cycles, then a sign-fix cycle.
// Define MUL_ADD_SIGNED_EN for two's-complement operands; otherwise all operands are unsigned.
module mul_add_seq
  import mul_add_seq_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N-1:0]     x,
  input  logic [M-1:0]     y,
  input  logic [M-1:0]     z,
  input  logic             start,
  output logic [N+M-1:0]   p,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(M + 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    xr;
  logic [N+M-1:0]  prod;
  logic [N+M-1:0]  zr;
  logic            neg;

  logic [N-1:0]    x_mag;
  logic [M-1:0]    y_mag;
  logic [N+M-1:0]  z_ext;
  logic            op_neg;
  logic [N:0]      sum;
  logic [N+M-1:0]  prod_fix;

`ifdef MUL_ADD_SIGNED_EN
  // Multiply magnitudes; the sign is reapplied to the finished product in FIX.
  assign x_mag  = x[N-1] ? -x : x;
  assign y_mag  = y[M-1] ? -y : y;
  assign z_ext  = {{N{z[M-1]}}, z};
  assign op_neg = x[N-1] ^ y[M-1];
`else
  assign x_mag  = x;
  assign y_mag  = y;
  assign z_ext  = {{N{1'b0}}, z};
  assign op_neg = 1'b0;
`endif

  // prod holds {partial sum, remaining multiplier bits}; each step adds x on lsb and shifts right.
  assign sum      = {1'b0, prod[N+M-1:M]} + (prod[0] ? {1'b0, xr} : '0);
  assign prod_fix = neg ? -prod : prod;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      xr   <= '0;
      prod <= '0;
      zr   <= '0;
      neg  <= 1'b0;
      p    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          xr   <= x_mag;
          prod <= {{N{1'b0}}, y_mag};
          zr   <= z_ext;
          neg  <= op_neg;
          cnt  <= CW'(M);
        end
        RUN: begin
          prod <= {sum, prod[M-1:1]};
          cnt  <= cnt - CW'(1);
        end
        FIX: begin
          p    <= prod_fix + zr;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_add_seq.sv
// Directed bench for mul_add_seq: reset values, latency/busy window, operand isolation, relaunch, abort, extremes.
module tb_mul_add_seq;
  import mul_add_seq_pkg::*;
  localparam int N = DEF_N;
  localparam int M = DEF_M;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   x;
  logic [M-1:0]   y;
  logic [M-1:0]   z;
  logic           start;
  logic [N+M-1:0] p;
  logic           busy;
  logic           done;

  int vectors = 0;
  int miscompares = 0;

  mul_add_seq #(.N(N), .M(M)) dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .z(z),
    .start(start), .p(p), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [N-1:0] xi, input logic [M-1:0] yi, input logic [M-1:0] zi);
    x = xi; y = yi; z = zi; start = 1'b1;
  endtask

  // Samples on falling edges until done; start drops after `hold` samples.
  task automatic wait_op(input int hold, input bit disturb, input string tag, input logic [N+M-1:0] exp_p);
    int cyc, bcnt;
    bit seen;
    cyc = 0; bcnt = 0; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
      if (cyc == hold) start = 1'b0;
      if (disturb) begin
        if (cyc == 4) start = 1'b1;
        if (cyc == 5) start = 1'b0;
        if (cyc == 6) x = '1;
      end
    end
    chk({tag, "_done"}, 64'(seen), 64'd1);
    chk({tag, "_lat"}, 64'(cyc), 64'(M + 2));
    chk({tag, "_busy"}, 64'(bcnt), 64'(M + 1));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_p"}, 64'(p), 64'(exp_p));
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int dn;
    resetn = 1'b0; start = 1'b0; x = '0; y = '0; z = '0;
    repeat (2) @(negedge clk);
    chk("rst_p", 64'(p), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // 16*4+0 = 0x40, start held for two cycles
    launch(32'd16, 16'd4, 16'd0);
    wait_op(2, 1'b0, "u16x4", 48'h000000000040);
    check_idle("u16x4");

    // operand/start changes during RUN must not matter
    launch(32'd3, 16'd5, 16'd3);
    wait_op(1, 1'b1, "u3x5p3", 48'h000000000012);
    check_idle("u3x5p3");

    launch(32'h3333332F, 16'd5, 16'd3);
    wait_op(1, 1'b0, "ubig", 48'h0000FFFFFFEE);
    check_idle("ubig");

    // start held high: relaunch right after done with freshly captured operands
    launch(32'd2, 16'd3, 16'd1);
    wait_op(1000, 1'b0, "rl_a", 48'h000000000007);
    x = 32'd10; y = 16'd10; z = 16'd5;
    wait_op(1, 1'b0, "rl_b", 48'h000000000069);
    check_idle("rl_b");

    // abort in the middle of RUN
    launch(32'd100, 16'd100, 16'd0);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_p", 64'(p), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("abort_quiet", 64'(dn), 64'd0);
    launch(32'd7, 16'd6, 16'd1);
    wait_op(1, 1'b0, "post_rst", 48'h00000000002B);
    check_idle("post_rst");

`ifdef MUL_ADD_SIGNED_EN
    launch(32'hFFFFFFFD, 16'hFFFB, 16'h0003);
    wait_op(1, 1'b0, "s_negneg", 48'h000000000012);
    check_idle("s_negneg");
    launch(32'hFFFFFFFD, 16'h0005, 16'hFFFD);
    wait_op(1, 1'b0, "s_negpos", 48'hFFFFFFFFFFEE);
    check_idle("s_negpos");
    launch(32'h80000000, 16'h8000, 16'h7FFF);
    wait_op(1, 1'b0, "s_ext", 48'h400000007FFF);
    check_idle("s_ext");
`else
    launch(32'hFFFFFFFF, 16'hFFFF, 16'hFFFF);
    wait_op(1, 1'b0, "u_ext", 48'hFFFF00000000);
    check_idle("u_ext");
    launch(32'h80000000, 16'h8000, 16'h7FFF);
    wait_op(1, 1'b0, "u_msb", 48'h400000007FFF);
    check_idle("u_msb");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
